vx_operand_collector: RTL and testbench

//  Banked GPR operand collector: next generation of the per-issue-slot operand stage, one instance per slot.
//  - Accepts an instruction from the scoreboard.
//  - Reads NUM_SRCS source registers from NUM_BANKS GPR banks; different banks are read in the same cycle, same-bank conflicts are serialised.
//  - Presents the instruction plus all operand data to dispatch through a one-entry output register.

---
 rtl/VX_gpu_pkg.sv | 26 ++
 rtl/vx_opc_bank.sv | 49 ++++
 rtl/vx_operand_collector.sv | 256 +++++++++++++++++++++++++
 tb/tb_vx_operand_collector.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// VX_gpu_pkg
//   Shared types and helpers for the banked operand collector.
//   - opc_state_t   : collector FSM state encoding
//   - opc_bank_sel  : bank index of a register id (low id bits)
//   - opc_bank_addr : row inside a bank, {wis, rid >> bank_bits}
//   Results are 32-bit; callers truncate to the width they need.
package VX_gpu_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } opc_state_t;

    function automatic int unsigned opc_bank_sel(input int unsigned rid,
                                                 input int unsigned bank_bits);
        return rid & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic int unsigned opc_bank_addr(input int unsigned wis,
                                                  input int unsigned rid,
                                                  input int unsigned bank_bits,
                                                  input int unsigned nr_bits);
        return (wis << (nr_bits - bank_bits)) | (rid >> bank_bits);
    endfunction

endpackage

// File: rtl/vx_opc_bank.sv
// vx_opc_bank
//   One GPR bank: NUM_THREADS independent lane memories, one read and one
//   write port each. The read address is registered; data appears the
//   cycle after the address edge. No read/write collision handling: a
//   write landing in the data cycle commits afterwards, so the read sees
//   the old value.
// Ports
//   clk    in   clock
//   raddr  in   read row (registered internally)
//   rdata  out  read data, lane 0 in LSBs
//   we     in   write enable
//   waddr  in   write row
//   wmask  in   per-lane write enable
//   wdata  in   write data, lane 0 in LSBs
module vx_opc_bank #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 6
) (
    input  logic                        clk,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [NUM_THREADS*XLEN-1:0] rdata,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [NUM_THREADS-1:0]      wmask,
    input  logic [NUM_THREADS*XLEN-1:0] wdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] raddr_q;

    always_ff @(posedge clk) begin
        raddr_q <= raddr;
    end

    for (genvar l = 0; l < NUM_THREADS; l++) begin : g_lane
        logic [XLEN-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && wmask[l]) begin
                mem[waddr] <= wdata[l*XLEN +: XLEN];
            end
        end

        assign rdata[l*XLEN +: XLEN] = mem[raddr_q];
    end

endmodule

// File: rtl/vx_operand_collector.sv
// vx_operand_collector
//   Per-issue-slot operand stage. Accepts an instruction, reads its source
//   registers from NUM_BANKS GPR banks (one read per bank per cycle, same-bank
//   sources serialised, duplicate ids share a read) and presents the
//   instruction plus operand data through a one-entry output register.
//   Optional: define VX_OPC_PERF_EN to add perf_conflict_cycles, a saturating
//   count of COLLECT cycles beyond the first read round.
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid/in_ready            instruction handshake from scoreboard
//   in_wis/in_tmask/in_rs/in_meta instruction fields (src0 in in_rs LSBs)
//   wb_valid/wb_wis/wb_rd/wb_tmask/wb_data  GPR writeback, never stalled
//   out_valid/out_ready          handshake to dispatch
//   out_wis/out_tmask/out_meta   registered instruction fields
//   out_rs_data                  operand data, src0 in LSBs
//   perf_conflict_cycles         only with VX_OPC_PERF_EN
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no collection running; may accept when output slot frees
// COLLECT | bank reads in flight for the latched instruction
module vx_operand_collector
    import VX_gpu_pkg::*;
#(
    parameter int NUM_SRCS    = 3,
    parameter int NUM_BANKS   = 2,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int WIS_W       = 1,
    parameter int META_W      = 64,
    localparam int WIS_BITS   = (WIS_W > 0) ? WIS_W : 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIS_BITS-1:0]                  in_wis,
    input  logic [NUM_THREADS-1:0]               in_tmask,
    input  logic [NUM_SRCS*NR_BITS-1:0]          in_rs,
    input  logic [META_W-1:0]                    in_meta,
    input  logic                                 wb_valid,
    input  logic [WIS_BITS-1:0]                  wb_wis,
    input  logic [NR_BITS-1:0]                   wb_rd,
    input  logic [NUM_THREADS-1:0]               wb_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]          wb_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIS_BITS-1:0]                  out_wis,
    output logic [NUM_THREADS-1:0]               out_tmask,
    output logic [META_W-1:0]                    out_meta,
    output logic [NUM_SRCS*NUM_THREADS*XLEN-1:0] out_rs_data
`ifdef VX_OPC_PERF_EN
    ,
    output logic [31:0]                          perf_conflict_cycles
`endif
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ADDR_W    = WIS_W + NR_BITS - BANK_BITS;
    localparam int OPD_W     = NUM_THREADS * XLEN;

    opc_state_t state_q, state_d;

    logic [WIS_BITS-1:0]    wis_q;
    logic [NUM_THREADS-1:0] tmask_q;
    logic [META_W-1:0]      meta_q;
    logic [NR_BITS-1:0]     rs_q [NUM_SRCS];
    logic [OPD_W-1:0]       opd_q [NUM_SRCS];

    logic [NUM_SRCS-1:0] pending_q;
    logic [NUM_SRCS-1:0] served_q;
    logic [NUM_SRCS-1:0] served_d;
    logic [NUM_SRCS-1:0] in_nz;
    logic [NUM_SRCS-1:0] rd_mask;
    logic [NR_BITS-1:0]  rd_rs [NUM_SRCS];
    logic [WIS_BITS-1:0] rd_wis;
    logic [NR_BITS-1:0]  pick_rid [NUM_BANKS];
    logic [ADDR_W-1:0]   bank_raddr [NUM_BANKS];
    logic [OPD_W-1:0]    bank_rdata [NUM_BANKS];
    logic [ADDR_W-1:0]   wb_addr;

    logic accept;
    logic all_zero;
    logic out_valid_q;
    logic out_valid_d;

    // Round selection. In IDLE the first round is built from the incoming
    // ids so its addresses are registered at the accept edge. In COLLECT,
    // sources whose data is being captured this cycle are excluded.
    always_comb begin
        in_nz    = '0;
        rd_mask  = '0;
        rd_wis   = in_wis;
        served_d = '0;
        for (int s = 0; s < NUM_SRCS; s++) begin
            in_nz[s] = (in_rs[s*NR_BITS +: NR_BITS] != '0);
            rd_rs[s] = in_rs[s*NR_BITS +: NR_BITS];
        end
        all_zero = (in_nz == '0);
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        if (state_q == IDLE) begin
            rd_mask = in_nz;
        end else begin
            rd_mask = pending_q & ~served_q;
            rd_wis  = wis_q;
            for (int s = 0; s < NUM_SRCS; s++) begin
                rd_rs[s] = rs_q[s];
            end
        end

        // Walk downwards so the lowest-index pending source wins its bank.
        for (int b = 0; b < NUM_BANKS; b++) begin
            pick_rid[b] = '0;
            for (int s = NUM_SRCS - 1; s >= 0; s--) begin
                if (rd_mask[s] && (opc_bank_sel(32'(rd_rs[s]), BANK_BITS) == b)) begin
                    pick_rid[b] = rd_rs[s];
                end
            end
            bank_raddr[b] = ADDR_W'(opc_bank_addr(32'(rd_wis), 32'(pick_rid[b]),
                                                  BANK_BITS, NR_BITS));
        end

        // Every pending source whose id matches its bank's pick rides the
        // same read, which covers duplicate ids.
        for (int s = 0; s < NUM_SRCS; s++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (rd_mask[s] && (opc_bank_sel(32'(rd_rs[s]), BANK_BITS) == b)
                    && (rd_rs[s] == pick_rid[b])) begin
                    served_d[s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (all_zero) begin
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (rd_mask == '0) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            pending_q   <= '0;
            served_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            served_q    <= (accept || (state_q == COLLECT)) ? served_d : '0;
            if (accept) begin
                pending_q <= in_nz;
            end else if (state_q == COLLECT) begin
                pending_q <= pending_q & ~served_q;
            end
        end
    end

    // Operand and instruction registers carry no reset; out_valid guards them.
    always_ff @(posedge clk) begin
        if (accept) begin
            wis_q   <= in_wis;
            tmask_q <= in_tmask;
            meta_q  <= in_meta;
            for (int s = 0; s < NUM_SRCS; s++) begin
                rs_q[s] <= in_rs[s*NR_BITS +: NR_BITS];
                if (!in_nz[s]) begin
                    opd_q[s] <= '0;
                end
            end
        end else if (state_q == COLLECT) begin
            for (int s = 0; s < NUM_SRCS; s++) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (served_q[s] && (opc_bank_sel(32'(rs_q[s]), BANK_BITS) == b)) begin
                        opd_q[s] <= bank_rdata[b];
                    end
                end
            end
        end
    end

`ifdef VX_OPC_PERF_EN
    logic        first_q;
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            first_q <= 1'b0;
            perf_q  <= '0;
        end else begin
            first_q <= accept && !all_zero;
            if ((state_q == COLLECT) && !first_q && (perf_q != '1)) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cycles = perf_q;
`endif

    assign wb_addr = ADDR_W'(opc_bank_addr(32'(wb_wis), 32'(wb_rd), BANK_BITS, NR_BITS));

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_we;

        assign bank_we = wb_valid && (wb_rd != '0)
                         && (opc_bank_sel(32'(wb_rd), BANK_BITS) == b);

        vx_opc_bank #(
            .NUM_THREADS (NUM_THREADS),
            .XLEN        (XLEN),
            .ADDR_W      (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b]),
            .we    (bank_we),
            .waddr (wb_addr),
            .wmask (wb_tmask),
            .wdata (wb_data)
        );
    end

    assign out_valid = out_valid_q;
    assign out_wis   = wis_q;
    assign out_tmask = tmask_q;
    assign out_meta  = meta_q;

    for (genvar s = 0; s < NUM_SRCS; s++) begin : g_out
        assign out_rs_data[s*OPD_W +: OPD_W] = opd_q[s];
    end

endmodule

// File: tb/tb_vx_operand_collector.sv
// Self-checking bench for vx_operand_collector (default parameters).
// Stimulus pushes expected results into a queue; a negedge monitor checks
// every presented output against the queue head, including arrival latency.
module tb_vx_operand_collector;

    localparam int NUM_SRCS    = 3;
    localparam int NUM_BANKS   = 2;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int NR_BITS     = 6;
    localparam int WIS_W       = 1;
    localparam int META_W      = 64;
    localparam int OPD_W       = NUM_THREADS * XLEN;
    localparam int NUM_REGS    = 1 << NR_BITS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [WIS_W-1:0] in_wis = '0;
    logic [NUM_THREADS-1:0] in_tmask = '0;
    logic [NUM_SRCS*NR_BITS-1:0] in_rs = '0;
    logic [META_W-1:0] in_meta = '0;
    logic wb_valid = 1'b0;
    logic [WIS_W-1:0] wb_wis = '0;
    logic [NR_BITS-1:0] wb_rd = '0;
    logic [NUM_THREADS-1:0] wb_tmask = '0;
    logic [OPD_W-1:0] wb_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [WIS_W-1:0] out_wis;
    logic [NUM_THREADS-1:0] out_tmask;
    logic [META_W-1:0] out_meta;
    logic [NUM_SRCS*OPD_W-1:0] out_rs_data;
`ifdef VX_OPC_PERF_EN
    logic [31:0] perf_conflict_cycles;
`endif

    always #5 clk = ~clk;

    vx_operand_collector #(
        .NUM_SRCS    (NUM_SRCS),
        .NUM_BANKS   (NUM_BANKS),
        .NUM_THREADS (NUM_THREADS),
        .XLEN        (XLEN),
        .NR_BITS     (NR_BITS),
        .WIS_W       (WIS_W),
        .META_W      (META_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wis      (in_wis),
        .in_tmask    (in_tmask),
        .in_rs       (in_rs),
        .in_meta     (in_meta),
        .wb_valid    (wb_valid),
        .wb_wis      (wb_wis),
        .wb_rd       (wb_rd),
        .wb_tmask    (wb_tmask),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wis     (out_wis),
        .out_tmask   (out_tmask),
        .out_meta    (out_meta),
        .out_rs_data (out_rs_data)
`ifdef VX_OPC_PERF_EN
        ,
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    typedef struct {
        logic [WIS_W-1:0]          wis;
        logic [NUM_THREADS-1:0]    tmask;
        logic [META_W-1:0]         meta;
        logic [NUM_SRCS*OPD_W-1:0] data;
        int                        lat;
        int                        acc;
    } exp_t;

    exp_t sb_q[$];
    logic [OPD_W-1:0] gpr [2][NUM_REGS];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int perf_exp = 0;
    int ready_mode = 2;
    bit seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // out_ready: 0 = random, 1 = held low, 2 = held high
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                timeout("unexpected_out_valid");
            end else begin
                e = sb_q[0];
                if (!seen) begin
                    check("latency", 512'(cyc - e.acc), 512'(e.lat));
                    seen = 1'b1;
                end
                check("out_fields", 512'({out_meta, out_wis, out_tmask, out_rs_data}),
                      512'({e.meta, e.wis, e.tmask, e.data}));
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic wb(input logic [WIS_W-1:0] w, input int rid,
                      input logic [NUM_THREADS-1:0] tm, input logic [OPD_W-1:0] d);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_wis   = w;
        wb_rd    = NR_BITS'(rid);
        wb_tmask = tm;
        wb_data  = d;
        if (rid != 0) begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (tm[l]) gpr[w][rid][l*XLEN +: XLEN] = d[l*XLEN +: XLEN];
            end
        end
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    // Expected latency: 1 + largest number of distinct nonzero ids in one bank.
    task automatic issue(input int r0, input int r1, input int r2, input logic [WIS_W-1:0] w);
        int r[NUM_SRCS];
        int cnt[NUM_BANKS];
        int waited;
        bit dup;
        exp_t e;
        r[0] = r0;
        r[1] = r1;
        r[2] = r2;
        e.wis   = w;
        e.tmask = NUM_THREADS'($urandom);
        e.meta  = {$urandom, $urandom};
        e.data  = '0;
        for (int b = 0; b < NUM_BANKS; b++) cnt[b] = 0;
        for (int s = 0; s < NUM_SRCS; s++) begin
            if (r[s] != 0) begin
                e.data[s*OPD_W +: OPD_W] = gpr[w][r[s]];
                dup = 1'b0;
                for (int t = 0; t < s; t++) if (r[t] == r[s]) dup = 1'b1;
                if (!dup) cnt[r[s] % NUM_BANKS]++;
            end
        end
        e.lat = 1;
        for (int b = 0; b < NUM_BANKS; b++) if (1 + cnt[b] > e.lat) e.lat = 1 + cnt[b];
        @(negedge clk);
        in_valid = 1'b1;
        in_wis   = w;
        in_tmask = e.tmask;
        in_meta  = e.meta;
        in_rs    = {NR_BITS'(r2), NR_BITS'(r1), NR_BITS'(r0)};
        waited = 0;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            timeout("accept");
            in_valid = 1'b0;
        end else begin
            e.acc = cyc;
            sb_q.push_back(e);
            if (e.lat > 2) perf_exp += e.lat - 2;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) timeout("drain");
    endtask

    function automatic int rr();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 9));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_in_ready", 512'(in_ready), 512'(1));
`ifdef VX_OPC_PERF_EN
        check("rst_perf", 512'(perf_conflict_cycles), 512'(0));
`endif

        for (int w = 0; w < 2; w++)
            for (int rid = 1; rid < NUM_REGS; rid++)
                wb(WIS_W'(w), rid, '1, {$urandom, $urandom, $urandom, $urandom});
        wb(0, 1, '1, {4{32'h11}});
        wb(0, 2, '1, {4{32'h22}});

        // all-x0 instruction, output held
        ready_mode = 1;
        issue(0, 0, 0, 0);
        @(negedge clk);
        check("t1_in_ready_blocked", 512'(in_ready), 512'(0));
        ready_mode = 2;
        drain();

        issue(1, 2, 0, 0);
        drain();
        issue(2, 4, 6, 0);
        drain();
`ifdef VX_OPC_PERF_EN
        check("t3_perf", 512'(perf_conflict_cycles), 512'(perf_exp));
`endif
        issue(3, 3, 3, 0);
        drain();

        // back-pressure
        ready_mode = 1;
        issue(5, 7, 2, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("t5_out_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_in_ready_low", 512'(in_ready), 512'(0));
            check("t5_out_valid_held", 512'(out_valid), 512'(1));
        end
        ready_mode = 2;
        @(negedge clk);
        check("t5_accept_on_ready", 512'(in_ready), 512'(1));
        issue(4, 1, 3, 1);
        drain();

        // reset during collection
        issue(2, 4, 6, 0);
        @(negedge clk);
        reset_n = 1'b0;
        sb_q.delete();
        perf_exp = 0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t6_in_ready", 512'(in_ready), 512'(1));
        for (int k = 0; k < 4; k++) begin
            check("t6_no_stale_out", 512'(out_valid), 512'(0));
            @(negedge clk);
        end
`ifdef VX_OPC_PERF_EN
        check("t6_perf_cleared", 512'(perf_conflict_cycles), 512'(0));
`endif
        issue(1, 0, 0, 0);
        drain();

        // randomized traffic
        ready_mode = 0;
        for (int it = 0; it < 15; it++) begin
            drain();
            repeat (3) wb(WIS_W'($urandom), int'($urandom_range(0, 15)), NUM_THREADS'($urandom),
                          {$urandom, $urandom, $urandom, $urandom});
            for (int k = 0; k < 12; k++) issue(rr(), rr(), rr(), WIS_W'($urandom));
        end
        drain();
`ifdef VX_OPC_PERF_EN
        check("final_perf", 512'(perf_conflict_cycles), 512'(perf_exp));
`endif
        check("queue_empty", 512'(sb_q.size()), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
